// File: rtl/col_result_reader.sv
// col_result_reader: walks the compressed-result RAM in slice-major order and streams
// each tagged column result over valid/ready, with a running per-slice sum.
module col_result_reader #(
   parameter int NUM_SLICE  = 2,
   parameter int SENSE_COL  = 3,
   parameter int RAM_ADDR_W = 10
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   output logic                  Ram_Rd_En,
   output logic [RAM_ADDR_W-1:0] Ram_Rd_Addr,
   input  logic [31:0]           Ram_Rd_Data,
   output logic                  Out_Valid,
   input  logic                  Out_Ready,
   output logic [31:0]           Out_Data,
   output logic [7:0]            Out_Slice,
   output logic [7:0]            Out_Col,
   output logic                  Out_Last_Col,
   output logic                  Out_Last,
   output logic [31:0]           Slice_Sum,
   output logic                  Busy,
   output logic                  Done
);
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
   localparam logic [7:0] LAST_COL   = 8'(SENSE_COL - 1);
   localparam logic [7:0] LAST_SLICE = 8'(NUM_SLICE - 1);
   state_t      state, state_n;
   logic [7:0]  slice, col, tag_slice, tag_col;
   logic        inflight, wp, rp, pop, push, fifo_pop, last_addr;
   logic [1:0]  cnt;
   logic [47:0] mem [2];
   logic [31:0] acc;

   // The returning read is the FIFO's input stage: with the FIFO empty it is shown
   // directly and only enqueued when downstream does not take it this cycle.
   assign {Out_Data, Out_Slice, Out_Col} = (cnt != 2'd0) ? mem[rp] :
                                           inflight ? {Ram_Rd_Data, tag_slice, tag_col} : '0;
   assign Out_Valid    = (cnt != 2'd0) || inflight;
   assign Out_Last_Col = Out_Valid && (Out_Col == LAST_COL);
   assign Out_Last     = Out_Last_Col && (Out_Slice == LAST_SLICE);
   assign Slice_Sum    = acc + Out_Data;
   assign pop          = Out_Valid && Out_Ready;
   assign push         = inflight && !((cnt == 2'd0) && pop);
   assign fifo_pop     = pop && (cnt != 2'd0);
   assign last_addr    = (col == LAST_COL) && (slice == LAST_SLICE);
   assign Ram_Rd_En    = (state == READ) && ((cnt + {1'b0, inflight}) < 2'd2);
   assign Busy         = (state == READ) || (state == DRAIN);
   assign Done         = state == DONE;

   always_comb begin
      state_n = state;
      if (state == IDLE && Start) state_n = READ;
      else if (state == READ && Ram_Rd_En && last_addr) state_n = DRAIN;
      else if (state == DRAIN && pop && Out_Last) state_n = DONE;
      else if (state == DONE) state_n = IDLE;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         slice       <= '0;
         col         <= '0;
         tag_slice   <= '0;
         tag_col     <= '0;
         Ram_Rd_Addr <= '0;
         inflight    <= 1'b0;
         wp          <= 1'b0;
         rp          <= 1'b0;
         cnt         <= '0;
         acc         <= '0;
      end else begin
         state    <= state_n;
         inflight <= Ram_Rd_En;
         if (Ram_Rd_En) begin
            tag_slice   <= slice;
            tag_col     <= col;
            Ram_Rd_Addr <= last_addr ? '0 : Ram_Rd_Addr + RAM_ADDR_W'(1);
            col         <= (col == LAST_COL) ? '0 : col + 8'd1;
            slice       <= last_addr ? '0 : (col == LAST_COL) ? slice + 8'd1 : slice;
         end
         if (push) wp <= ~wp;
         if (fifo_pop) rp <= ~rp;
         cnt <= cnt + 2'(push) - 2'(fifo_pop);
         if (pop) acc <= Out_Last_Col ? '0 : acc + Out_Data;
      end
   end

   always_ff @(posedge Clk) begin
      if (push) mem[wp] <= {Ram_Rd_Data, tag_slice, tag_col};
   end
endmodule

// File: tb/tb_col_result_reader.sv
// tb_col_result_reader: randomized scoreboard bench; expected words are computed from
// the RAM image in slice-major order and checked by an independent monitor.
module tb_col_result_reader;
   localparam int NS = 2, SC = 3, N = NS * SC;
   logic        Clk = 0, Reset = 1, Start = 0, Out_Ready = 0;
   logic        Ram_Rd_En, Out_Valid, Out_Last_Col, Out_Last, Busy, Done;
   logic [9:0]  Ram_Rd_Addr;
   logic [31:0] Ram_Rd_Data = 0, Out_Data, Slice_Sum;
   logic [7:0]  Out_Slice, Out_Col;
   logic        s_start = 0, s_rd_en, s_valid, s_lc, s_l, s_busy, s_done;
   logic [9:0]  s_addr;
   logic [31:0] s_rd_data = 0, s_data, s_sum;
   logic [7:0]  s_slice, s_col;

   typedef struct {logic [31:0] d; logic [7:0] s, c; logic lc, l; logic [31:0] sum;} exp_t;
   exp_t        exp_q[$];
   exp_t        e;
   logic [31:0] ram [N];
   int          vec = 0, miss = 0, issued = 0, accepted = 0, mode = 0, cyc = 0, ncyc = 0;
   int          first_hs = -1, last_hs = -1;
   logic        done_next = 0, done_exp = 0, prev_stall = 0;
   logic [48:0] prev_word = 0;
   logic [5:0]  pat = 6'b101001;

   col_result_reader #(.NUM_SLICE(NS), .SENSE_COL(SC), .RAM_ADDR_W(10)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Ram_Rd_En(Ram_Rd_En), .Ram_Rd_Addr(Ram_Rd_Addr),
      .Ram_Rd_Data(Ram_Rd_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
      .Out_Slice(Out_Slice), .Out_Col(Out_Col), .Out_Last_Col(Out_Last_Col), .Out_Last(Out_Last),
      .Slice_Sum(Slice_Sum), .Busy(Busy), .Done(Done));

   col_result_reader #(.NUM_SLICE(1), .SENSE_COL(1), .RAM_ADDR_W(10)) dut1 (
      .Clk(Clk), .Reset(Reset), .Start(s_start), .Ram_Rd_En(s_rd_en), .Ram_Rd_Addr(s_addr),
      .Ram_Rd_Data(s_rd_data), .Out_Valid(s_valid), .Out_Ready(1'b1), .Out_Data(s_data),
      .Out_Slice(s_slice), .Out_Col(s_col), .Out_Last_Col(s_lc), .Out_Last(s_l),
      .Slice_Sum(s_sum), .Busy(s_busy), .Done(s_done));

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (Ram_Rd_En) Ram_Rd_Data <= (int'(Ram_Rd_Addr) < N) ? ram[int'(Ram_Rd_Addr)] : 32'hDEAD_BEEF;
      if (s_rd_en) s_rd_data <= 32'h5A5A_0000 | {22'h0, s_addr};
   end

   always @(posedge Clk) begin
      #1;
      cyc++;
      Out_Ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 6] :
                  (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h want %0h", n, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks protocol rules.
   always @(negedge Clk) begin
      if (!Reset) begin
         ncyc++;
         done_exp  = done_next;
         done_next = 0;
         if (Done || done_exp) chk("done pulse", Done, done_exp);
         if (prev_stall) chk("stall hold", {Out_Valid, Out_Data, Out_Slice, Out_Col}, prev_word);
         if (Ram_Rd_En) begin
            chk("read room", (issued - accepted) < 2, 1);
            chk("read addr", Ram_Rd_Addr, issued);
            issued++;
         end
         if (Out_Valid && Out_Ready) begin
            if (exp_q.size() == 0) begin
               vec++;
               miss++;
               $display("FAIL extra word: got %0h want none", Out_Data);
            end else begin
               e = exp_q.pop_front();
               chk("data", Out_Data, e.d);
               chk("tags", {Out_Slice, Out_Col}, {e.s, e.c});
               chk("last flags", {Out_Last_Col, Out_Last}, {e.lc, e.l});
               if (e.lc) chk("slice sum", Slice_Sum, e.sum);
               accepted++;
               if (first_hs < 0) first_hs = ncyc;
               last_hs = ncyc;
               if (e.l) done_next = 1;
            end
         end
         prev_stall = Out_Valid && !Out_Ready;
         prev_word  = {1'b1, Out_Data, Out_Slice, Out_Col};
      end
   end

   // Called at posedge+1; builds the expected stream from the RAM image, then pulses Start.
   task automatic run_start(input bit lat);
      exp_t x;
      logic [31:0] sum = 0;
      for (int s = 0; s < NS; s++)
         for (int c = 0; c < SC; c++) begin
            sum += ram[s * SC + c];
            x.d = ram[s * SC + c]; x.s = 8'(s); x.c = 8'(c);
            x.lc = (c == SC - 1); x.l = x.lc && (s == NS - 1); x.sum = sum;
            exp_q.push_back(x);
            if (x.lc) sum = 0;
         end
      issued = 0; accepted = 0; first_hs = -1;
      Start = 1;
      if (lat) begin @(negedge Clk); chk("no valid c0", Out_Valid, 0); end
      @(posedge Clk); #1 Start = 0;
      if (lat) begin
         @(negedge Clk); chk("busy c1", {Busy, Out_Valid}, 2'b10);
         @(negedge Clk); chk("valid c2", {Out_Valid, Out_Data}, {1'b1, ram[0]});
      end
   endtask

   task automatic wait_done();
      int k = 0;
      while (!Done && k < 300) begin @(negedge Clk); #2; k++; end
      if (!Done) begin vec++; miss++; $display("FAIL done timeout: got 0 want 1"); end
      chk("queue drained", exp_q.size(), 0);
      @(posedge Clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge Clk);
      #1;
      chk("reset ctl", {Ram_Rd_En, Out_Valid, Out_Last_Col, Out_Last, Busy, Done, Ram_Rd_Addr, Out_Slice, Out_Col}, 0);
      chk("reset data", {Out_Data, Slice_Sum}, 0);
      Reset = 0;
      ram = '{10, 9, 0, 20, 18, 0};
      @(posedge Clk); #1;
      mode = 0; run_start(1); wait_done();
      chk("stream span", last_hs - first_hs, 5);
      mode = 1; run_start(0); wait_done();
      mode = 3; run_start(0);
      repeat (18) @(posedge Clk);
      #1 chk("held reads", issued, 2);
      chk("held head", {Out_Valid, Out_Data}, {1'b1, 32'd10});
      mode = 0; wait_done();
      run_start(0);
      for (int k = 0; k < 50 && accepted < 4; k++) begin @(negedge Clk); #2; end
      Reset = 1;
      #1 chk("abort ctl", {Ram_Rd_En, Out_Valid, Out_Last_Col, Out_Last, Busy, Done, Ram_Rd_Addr, Out_Slice, Out_Col}, 0);
      chk("abort data", {Out_Data, Slice_Sum}, 0);
      exp_q.delete(); issued = 0; accepted = 0; done_next = 0; prev_stall = 0;
      repeat (2) @(posedge Clk);
      #1 Reset = 0;
      repeat (3) begin @(negedge Clk); chk("idle after abort", {Done, Busy, Out_Valid}, 0); end
      @(posedge Clk); #1;
      run_start(1); wait_done();
      ram = '{32'hFFFF_FFFF, 2, 0, $urandom, $urandom, $urandom};
      mode = 2; run_start(0);
      repeat (3) @(posedge Clk);
      #1 Start = 1;
      @(posedge Clk); #1 Start = 0;
      wait_done();
      repeat (4) begin @(negedge Clk); chk("ignored start", {Busy, Out_Valid}, 0); end
      @(posedge Clk); #1;
      for (int it = 0; it < 6; it++) begin
         foreach (ram[i]) ram[i] = (it % 2) ? $urandom : $urandom_range(0, 100);
         mode = (it % 3 == 0) ? 1 : 2;
         run_start(0); wait_done();
      end
      s_start = 1;
      @(posedge Clk); #1 s_start = 0;
      for (int k = 0; k < 10 && !s_valid; k++) begin @(negedge Clk); #2; end
      chk("1x1 word", {s_valid, s_lc, s_l, s_slice, s_col, s_data}, {3'b111, 16'h0, 32'h5A5A_0000});
      chk("1x1 sum", s_sum, 32'h5A5A_0000);
      @(negedge Clk); chk("1x1 done", {s_done, s_busy, s_valid}, 3'b100);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule

// File: doc/col_result_reader.md
Name: col_result_reader

Overview:
- Read-side counterpart of the column compression stage.
- After compression finishes, it walks the compressed-result RAM in slice-major order, reading address slice*SENSE_COL+col.
- It streams each stored 32-bit column result to the downstream recovery/export logic over a valid/ready handshake, tagged with slice and column indices.
- It also emits a running per-slice sum on the last column of each slice.

Parameters:
- NUM_SLICE, 2, number of slices stored in RAM (1..255)
- SENSE_COL, 3, number of sensing columns per slice (1..255)
- RAM_ADDR_W, 10, RAM address width; NUM_SLICE*SENSE_COL must be <= 2^RAM_ADDR_W

Ports:
- Clk  input  1  single clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  one-cycle pulse; begins a full readout; ignored unless idle
- Ram_Rd_En  output  1  RAM read enable
- Ram_Rd_Addr  output  RAM_ADDR_W  RAM read address
- Ram_Rd_Data  input  32  RAM read data, valid exactly 1 cycle after Ram_Rd_En
- Out_Valid  output  1  output word valid
- Out_Ready  input  1  downstream accepts the word when Out_Valid&&Out_Ready
- Out_Data  output  32  column result
- Out_Slice  output  8  slice index of Out_Data
- Out_Col  output  8  column index of Out_Data
- Out_Last_Col  output  1  Out_Col==SENSE_COL-1
- Out_Last  output  1  last word of the readout (last slice, last column)
- Slice_Sum  output  32  sum of the slice's columns including the current word; meaningful when Out_Last_Col
- Busy  output  1  high from accepted Start until Done
- Done  output  1  one-cycle pulse after the final handshake

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Internal slice/col/address counters 0.
  - FIFO empty.
  - Any in-flight read is discarded.
  - Reset mid-readout aborts the readout with no Done.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: Start=1 -> READ, Busy=1 next cycle. Start while not IDLE is ignored.
  - READ: issues reads. After the read for address NUM_SLICE*SENSE_COL-1 is issued -> DRAIN.
  - DRAIN: no new reads. When the FIFO is empty, no read is in flight, and the last handshake has completed -> DONE.
  - DONE: Done=1 and Busy=0 for one cycle -> IDLE.
- Read issue:
  - Address is generated by incrementing col, wrapping to 0 at SENSE_COL-1 and incrementing slice. No multiplier.
  - Ram_Rd_Addr is linear: 0,1,2,... up to NUM_SLICE*SENSE_COL-1.
  - A read is issued in a cycle only if (fifo_count + inflight) < 2, where inflight is 0 or 1.
- Buffering:
  - 2-entry FIFO holding {data, slice, col}.
  - Read data is captured 1 cycle after Ram_Rd_En.
  - The FIFO never overflows under any Out_Ready pattern.
  - Out_* are driven from the FIFO head.
  - Out_Valid = FIFO not empty.
  - Out_Data and tags are held stable while Out_Valid&&!Out_Ready.
- Throughput: with Out_Ready held high, one word per cycle after a 2-cycle initial latency. The first Out_Valid appears 2 cycles after the Start cycle.
- Slice_Sum:
  - Accumulator is updated on each handshake, 32-bit wrap-around.
  - Slice_Sum output = acc + Out_Data (combinational on the head word).
  - acc is cleared on a handshake with Out_Last_Col=1.
- Simultaneous events:
  - FIFO push and pop in the same cycle leaves the count unchanged.
  - Start arriving in the DONE cycle is ignored.
- NUM_SLICE=1 and SENSE_COL=1 must work: a single word, with both Out_Last_Col and Out_Last high.

Test Plan:
- Preload RAM[0..5]=10,9,0,20,18,0. NUM_SLICE=2, SENSE_COL=3, Out_Ready=1, pulse Start.
  - Required: words 10,9,0,20,18,0 on consecutive cycles, first valid 2 cycles after Start.
  - Slice_Sum=19 at (slice0,col2) and 38 at (slice1,col2).
  - Out_Last only on the 6th word; Done 1 cycle after the last handshake.
- Same preload, Out_Ready toggled 1,0,0,1,0,1...
  - Required: no word lost or duplicated.
  - Out_Data stable while stalled.
  - Ram_Rd_En never issued when FIFO+inflight==2.
- Out_Ready=0 for 20 cycles after Start.
  - Required: exactly 2 reads issued (addr 0,1), Out_Valid=1 with data 10, then the remaining words stream normally on release.
- Assert Reset during the 4th word.
  - Required: all outputs 0 the same cycle, no Done.
  - A new Start then replays from address 0 with data 10.
- RAM[0..5]=32'hFFFFFFFF,2,0,...
  - Required: Slice_Sum at slice0 col2 = 1 (wrap).
  - A second Start pulse issued mid-readout is ignored.
